// File: rtl/axi_mem_pkg.sv
// Shared encodings for the AXI4 burst memory: burst types, response codes, FSM states.
package axi_mem_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

    // AXI4 only defines WRAP bursts of 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi4_burst_mem_if.sv
// AXI4 slave bus bundle for axi4_burst_mem; the memory uses the slave modport.
interface axi4_burst_mem_if #(
    parameter int unsigned G_ADDR_WIDTH = 6,
    parameter int unsigned G_DATA_WIDTH = 32,
    parameter int unsigned G_ID_WIDTH   = 1
) ();

    logic [G_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [7:0]                S_AXI_AWLEN;
    logic [2:0]                S_AXI_AWSIZE;
    logic [1:0]                S_AXI_AWBURST;
    logic [G_ID_WIDTH-1:0]     S_AXI_AWID;
    logic [2:0]                S_AXI_AWPROT;
    logic                      S_AXI_AWVALID;
    logic                      S_AXI_AWREADY;

    logic [G_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [G_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                      S_AXI_WLAST;
    logic                      S_AXI_WVALID;
    logic                      S_AXI_WREADY;

    logic [G_ID_WIDTH-1:0]     S_AXI_BID;
    logic [1:0]                S_AXI_BRESP;
    logic                      S_AXI_BVALID;
    logic                      S_AXI_BREADY;

    logic [G_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [7:0]                S_AXI_ARLEN;
    logic [2:0]                S_AXI_ARSIZE;
    logic [1:0]                S_AXI_ARBURST;
    logic [G_ID_WIDTH-1:0]     S_AXI_ARID;
    logic [2:0]                S_AXI_ARPROT;
    logic                      S_AXI_ARVALID;
    logic                      S_AXI_ARREADY;

    logic [G_DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [G_ID_WIDTH-1:0]     S_AXI_RID;
    logic [1:0]                S_AXI_RRESP;
    logic                      S_AXI_RLAST;
    logic                      S_AXI_RVALID;
    logic                      S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWID,
               S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARID,
               S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RID, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWID,
               S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARID,
               S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RID, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        output S_AXI_RREADY
    );

endinterface

// File: rtl/axi_mem_addr_gen.sv
// Combinational AXI4 next-beat address (FIXED/INCR/WRAP) and illegal-burst flag.
// Illegal-burst detection is only active when AXI_MEM_ERR_CHECK_EN is defined.
module axi_mem_addr_gen
    import axi_mem_pkg::*;
#(
    parameter int unsigned G_ADDR_WIDTH = 6,
    parameter int unsigned G_DATA_WIDTH = 32
) (
    input  logic [G_ADDR_WIDTH-1:0] addr_i,
    input  logic [7:0]              len_i,
    input  logic [2:0]              size_i,
    input  logic [1:0]              burst_i,
    output logic [G_ADDR_WIDTH-1:0] next_addr_o,
    output logic                    illegal_o
);

    localparam logic [2:0] MAX_SIZE = 3'($clog2(G_DATA_WIDTH / 8));
    localparam logic [G_ADDR_WIDTH-1:0] A_ONE = {{(G_ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]              eff_size;
    logic [G_ADDR_WIDTH-1:0] size_bytes;
    logic [G_ADDR_WIDTH-1:0] aligned;
    logic [G_ADDR_WIDTH-1:0] incr;
    logic [G_ADDR_WIDTH-1:0] wrap_mask;
    logic                    wrap_ok;

    always_comb begin
        eff_size   = (size_i > MAX_SIZE) ? MAX_SIZE : size_i;
        size_bytes = A_ONE << eff_size;
        aligned    = addr_i & ~(size_bytes - A_ONE);
        incr       = aligned + size_bytes;
        wrap_ok    = (burst_i == BURST_WRAP) && wrap_len_ok(len_i);
        // Block size is a power of two; a block covering the whole space gives an all-ones mask.
        wrap_mask  = (G_ADDR_WIDTH'({1'b0, len_i[3:0]} + 5'd1) << eff_size) - A_ONE;

        if (burst_i == BURST_FIXED) begin
            next_addr_o = addr_i;
        end else if (wrap_ok) begin
            next_addr_o = (aligned & ~wrap_mask) | (incr & wrap_mask);
        end else begin
            next_addr_o = incr;
        end

`ifdef AXI_MEM_ERR_CHECK_EN
        illegal_o = ((burst_i == BURST_WRAP) && !wrap_len_ok(len_i)) || (size_i > MAX_SIZE);
`else
        illegal_o = 1'b0;
`endif
    end

endmodule

// File: rtl/axi4_burst_mem.sv
// AXI4 burst slave memory with independent read/write FSMs, byte strobes and ID echo.
// Define AXI_MEM_ERR_CHECK_EN to flag illegal bursts with SLVERR.
module axi4_burst_mem
    import axi_mem_pkg::*;
#(
    parameter int unsigned G_ADDR_WIDTH = 6,
    parameter int unsigned G_DATA_WIDTH = 32,
    parameter int unsigned G_ID_WIDTH   = 1
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    axi4_burst_mem_if.slave  s_axi
);

    localparam int unsigned STRB_W = G_DATA_WIDTH / 8;
    localparam int unsigned LOG2B  = $clog2(STRB_W);
    localparam int unsigned WORDS  = 1 << (G_ADDR_WIDTH - LOG2B);

    typedef logic [G_ADDR_WIDTH-1:0] addr_t;
    typedef logic [G_DATA_WIDTH-1:0] data_t;
    typedef logic [G_ID_WIDTH-1:0]   id_t;

    data_t mem_q [WORDS];

    logic alive_q, alive_d;

    w_state_e w_state_q, w_state_d;
    addr_t    waddr_q, waddr_d;
    logic [7:0] wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [2:0] wsize_q, wsize_d;
    logic [1:0] wburst_q, wburst_d;
    id_t      bid_q, bid_d;
    logic     werr_q, werr_d;

    r_state_e r_state_q, r_state_d;
    addr_t    raddr_q, raddr_d;
    logic [7:0] rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [2:0] rsize_q, rsize_d;
    logic [1:0] rburst_q, rburst_d;
    id_t      rid_q, rid_d;
    logic     rerr_q, rerr_d;
    data_t    rdata_q, rdata_d;

    addr_t      wg_addr, w_next, rg_addr, r_next, r_fetch_addr;
    logic [7:0] wg_len, rg_len;
    logic [2:0] wg_size, rg_size;
    logic [1:0] wg_burst, rg_burst;
    logic       w_illegal, r_illegal, wlast_bad, beat_err, mem_we, r_fetch;

    // Generators see the incoming request while idle and the live burst otherwise.
    always_comb begin
        if (w_state_q == W_IDLE) begin
            wg_addr  = s_axi.S_AXI_AWADDR;
            wg_len   = s_axi.S_AXI_AWLEN;
            wg_size  = s_axi.S_AXI_AWSIZE;
            wg_burst = s_axi.S_AXI_AWBURST;
        end else begin
            wg_addr  = waddr_q;
            wg_len   = wlen_q;
            wg_size  = wsize_q;
            wg_burst = wburst_q;
        end
        if (r_state_q == R_IDLE) begin
            rg_addr  = s_axi.S_AXI_ARADDR;
            rg_len   = s_axi.S_AXI_ARLEN;
            rg_size  = s_axi.S_AXI_ARSIZE;
            rg_burst = s_axi.S_AXI_ARBURST;
        end else begin
            rg_addr  = raddr_q;
            rg_len   = rlen_q;
            rg_size  = rsize_q;
            rg_burst = rburst_q;
        end
    end

    axi_mem_addr_gen #(.G_ADDR_WIDTH(G_ADDR_WIDTH), .G_DATA_WIDTH(G_DATA_WIDTH)) u_wgen (
        .addr_i(wg_addr), .len_i(wg_len), .size_i(wg_size), .burst_i(wg_burst),
        .next_addr_o(w_next), .illegal_o(w_illegal)
    );

    axi_mem_addr_gen #(.G_ADDR_WIDTH(G_ADDR_WIDTH), .G_DATA_WIDTH(G_DATA_WIDTH)) u_rgen (
        .addr_i(rg_addr), .len_i(rg_len), .size_i(rg_size), .burst_i(rg_burst),
        .next_addr_o(r_next), .illegal_o(r_illegal)
    );

    assign alive_d = 1'b1;

    always_comb begin
        w_state_d = w_state_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wcnt_d    = wcnt_q;
        wsize_d   = wsize_q;
        wburst_d  = wburst_q;
        bid_d     = bid_q;
        werr_d    = werr_q;
        mem_we    = 1'b0;
`ifdef AXI_MEM_ERR_CHECK_EN
        wlast_bad = s_axi.S_AXI_WLAST != (wcnt_q == wlen_q);
`else
        wlast_bad = 1'b0;
`endif
        // A WLAST mismatch is only visible on its own beat; it blocks that beat and all later ones.
        beat_err  = werr_q | wlast_bad;

        case (w_state_q)
            W_IDLE: begin
                if (alive_q && s_axi.S_AXI_AWVALID) begin
                    waddr_d   = s_axi.S_AXI_AWADDR;
                    wlen_d    = s_axi.S_AXI_AWLEN;
                    wsize_d   = s_axi.S_AXI_AWSIZE;
                    wburst_d  = s_axi.S_AXI_AWBURST;
                    bid_d     = s_axi.S_AXI_AWID;
                    wcnt_d    = '0;
                    werr_d    = w_illegal;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (s_axi.S_AXI_WVALID) begin
                    werr_d = beat_err;
                    mem_we = !beat_err;
                    if (wcnt_q == wlen_q) begin
                        w_state_d = W_RESP;
                    end else begin
                        waddr_d = w_next;
                        wcnt_d  = wcnt_q + 8'd1;
                    end
                end
            end
            W_RESP: begin
                if (s_axi.S_AXI_BREADY) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d    = r_state_q;
        raddr_d      = raddr_q;
        rlen_d       = rlen_q;
        rcnt_d       = rcnt_q;
        rsize_d      = rsize_q;
        rburst_d     = rburst_q;
        rid_d        = rid_q;
        rerr_d       = rerr_q;
        rdata_d      = rdata_q;
        r_fetch      = 1'b0;
        r_fetch_addr = raddr_q;

        case (r_state_q)
            R_IDLE: begin
                if (alive_q && s_axi.S_AXI_ARVALID) begin
                    raddr_d      = s_axi.S_AXI_ARADDR;
                    rlen_d       = s_axi.S_AXI_ARLEN;
                    rsize_d      = s_axi.S_AXI_ARSIZE;
                    rburst_d     = s_axi.S_AXI_ARBURST;
                    rid_d        = s_axi.S_AXI_ARID;
                    rcnt_d       = '0;
                    rerr_d       = r_illegal;
                    r_fetch      = 1'b1;
                    r_fetch_addr = s_axi.S_AXI_ARADDR;
                    r_state_d    = R_DATA;
                end
            end
            R_DATA: begin
                if (s_axi.S_AXI_RREADY) begin
                    if (rcnt_q == rlen_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        raddr_d      = r_next;
                        rcnt_d       = rcnt_q + 8'd1;
                        r_fetch      = 1'b1;
                        r_fetch_addr = r_next;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase

        // Reads sample mem_q before this edge's write lands, so a same-word collision returns old data.
        if (r_fetch) begin
            rdata_d = rerr_d ? '0 : mem_q[r_fetch_addr[G_ADDR_WIDTH-1:LOG2B]];
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            alive_q   <= 1'b0;
            w_state_q <= W_IDLE;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wcnt_q    <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
            bid_q     <= '0;
            werr_q    <= 1'b0;
            r_state_q <= R_IDLE;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            rid_q     <= '0;
            rerr_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            alive_q   <= alive_d;
            w_state_q <= w_state_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wcnt_q    <= wcnt_d;
            wsize_q   <= wsize_d;
            wburst_q  <= wburst_d;
            bid_q     <= bid_d;
            werr_q    <= werr_d;
            r_state_q <= r_state_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rcnt_q    <= rcnt_d;
            rsize_q   <= rsize_d;
            rburst_q  <= rburst_d;
            rid_q     <= rid_d;
            rerr_q    <= rerr_d;
            rdata_q   <= rdata_d;
        end
    end

    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (s_axi.S_AXI_WSTRB[b]) begin
                    mem_q[waddr_q[G_ADDR_WIDTH-1:LOG2B]][8*b +: 8] <= s_axi.S_AXI_WDATA[8*b +: 8];
                end
            end
        end
    end

    assign s_axi.S_AXI_AWREADY = alive_q && (w_state_q == W_IDLE);
    assign s_axi.S_AXI_WREADY  = (w_state_q == W_DATA);
    assign s_axi.S_AXI_BVALID  = (w_state_q == W_RESP);
    assign s_axi.S_AXI_BID     = bid_q;
    assign s_axi.S_AXI_BRESP   = ((w_state_q == W_RESP) && werr_q) ? RESP_SLVERR : RESP_OKAY;

    assign s_axi.S_AXI_ARREADY = alive_q && (r_state_q == R_IDLE);
    assign s_axi.S_AXI_RVALID  = (r_state_q == R_DATA);
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RID     = rid_q;
    assign s_axi.S_AXI_RLAST   = (r_state_q == R_DATA) && (rcnt_q == rlen_q);
    assign s_axi.S_AXI_RRESP   = ((r_state_q == R_DATA) && rerr_q) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_axi4_burst_mem.sv
// Directed self-checking bench for axi4_burst_mem (32-bit data, 64-byte space).
module tb_axi4_burst_mem;
    import axi_mem_pkg::*;

    logic ACLK = 1'b0;
    logic ARESETn = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 ACLK = ~ACLK;

    axi4_burst_mem_if #(.G_ADDR_WIDTH(6), .G_DATA_WIDTH(32), .G_ID_WIDTH(1)) bus ();

    axi4_burst_mem #(.G_ADDR_WIDTH(6), .G_DATA_WIDTH(32), .G_ID_WIDTH(1)) dut (
        .ACLK(ACLK),
        .ARESETn(ARESETn),
        .s_axi(bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic aw(input logic [5:0] a, input logic [7:0] len, input logic [2:0] sz,
                      input logic [1:0] bu, input logic id);
        bus.S_AXI_AWADDR = a; bus.S_AXI_AWLEN = len; bus.S_AXI_AWSIZE = sz;
        bus.S_AXI_AWBURST = bu; bus.S_AXI_AWID = id; bus.S_AXI_AWVALID = 1'b1;
        for (int n = 0; n < 20 && !bus.S_AXI_AWREADY; n++) tick();
        chk("awready", 64'(bus.S_AXI_AWREADY), 64'd1);
        tick();
        bus.S_AXI_AWVALID = 1'b0;
    endtask

    task automatic wb(input logic [31:0] d, input logic [3:0] strb, input logic last);
        bus.S_AXI_WDATA = d; bus.S_AXI_WSTRB = strb; bus.S_AXI_WLAST = last;
        bus.S_AXI_WVALID = 1'b1;
        for (int n = 0; n < 20 && !bus.S_AXI_WREADY; n++) tick();
        chk("wready", 64'(bus.S_AXI_WREADY), 64'd1);
        tick();
        bus.S_AXI_WVALID = 1'b0;
    endtask

    task automatic bchk(input string tag, input logic [1:0] resp, input logic id);
        chk({tag, "_bvalid"}, 64'(bus.S_AXI_BVALID), 64'd1);
        chk({tag, "_bresp"}, 64'(bus.S_AXI_BRESP), 64'(resp));
        chk({tag, "_bid"}, 64'(bus.S_AXI_BID), 64'(id));
        tick();
    endtask

    task automatic ar(input logic [5:0] a, input logic [7:0] len, input logic [2:0] sz,
                      input logic [1:0] bu, input logic id);
        bus.S_AXI_ARADDR = a; bus.S_AXI_ARLEN = len; bus.S_AXI_ARSIZE = sz;
        bus.S_AXI_ARBURST = bu; bus.S_AXI_ARID = id; bus.S_AXI_ARVALID = 1'b1;
        for (int n = 0; n < 20 && !bus.S_AXI_ARREADY; n++) tick();
        chk("arready", 64'(bus.S_AXI_ARREADY), 64'd1);
        tick();
        bus.S_AXI_ARVALID = 1'b0;
    endtask

    task automatic rb(input string tag, input logic [31:0] d, input logic last,
                      input logic [1:0] resp, input logic id);
        chk({tag, "_rvalid"}, 64'(bus.S_AXI_RVALID), 64'd1);
        chk({tag, "_rdata"}, 64'(bus.S_AXI_RDATA), 64'(d));
        chk({tag, "_rlast"}, 64'(bus.S_AXI_RLAST), 64'(last));
        chk({tag, "_rresp"}, 64'(bus.S_AXI_RRESP), 64'(resp));
        chk({tag, "_rid"}, 64'(bus.S_AXI_RID), 64'(id));
        tick();
    endtask

    initial begin
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWLEN = '0; bus.S_AXI_AWSIZE = '0;
        bus.S_AXI_AWBURST = '0; bus.S_AXI_AWID = '0; bus.S_AXI_AWPROT = '0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARLEN = '0; bus.S_AXI_ARSIZE = '0;
        bus.S_AXI_ARBURST = '0; bus.S_AXI_ARID = '0; bus.S_AXI_ARPROT = '0;
        bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WLAST = 1'b0;
        bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;

        // Reset state
        #2 ARESETn = 1'b0;
        tick(); tick();
        chk("rst_awready", 64'(bus.S_AXI_AWREADY), 64'd0);
        chk("rst_arready", 64'(bus.S_AXI_ARREADY), 64'd0);
        chk("rst_wready", 64'(bus.S_AXI_WREADY), 64'd0);
        chk("rst_bvalid", 64'(bus.S_AXI_BVALID), 64'd0);
        chk("rst_rvalid", 64'(bus.S_AXI_RVALID), 64'd0);
        chk("rst_rdata", 64'(bus.S_AXI_RDATA), 64'd0);
        ARESETn = 1'b1;
        #1 chk("rel_awready_pre", 64'(bus.S_AXI_AWREADY), 64'd0);
        tick();
        chk("rel_awready", 64'(bus.S_AXI_AWREADY), 64'd1);
        chk("rel_arready", 64'(bus.S_AXI_ARREADY), 64'd1);

        // Single unaligned write to word 1, then read it back
        aw(6'h05, 8'd0, 3'd2, BURST_INCR, 1'b1);
        wb(32'h07563314, 4'hF, 1'b1);
        bchk("single", RESP_OKAY, 1'b1);
        ar(6'h04, 8'd0, 3'd2, BURST_INCR, 1'b1);
        rb("single", 32'h07563314, 1'b1, RESP_OKAY, 1'b1);

        // INCR 4-beat write with BVALID held under BREADY=0, then INCR read
        aw(6'h10, 8'd3, 3'd2, BURST_INCR, 1'b0);
        wb(32'd1, 4'hF, 1'b0); wb(32'd2, 4'hF, 1'b0); wb(32'd3, 4'hF, 1'b0);
        bus.S_AXI_BREADY = 1'b0;
        wb(32'd4, 4'hF, 1'b1);
        tick();
        chk("bhold_bvalid", 64'(bus.S_AXI_BVALID), 64'd1);
        chk("bhold_awready", 64'(bus.S_AXI_AWREADY), 64'd0);
        bus.S_AXI_BREADY = 1'b1;
        bchk("incr", RESP_OKAY, 1'b0);
        ar(6'h10, 8'd3, 3'd2, BURST_INCR, 1'b0);
        chk("incr_arready_busy", 64'(bus.S_AXI_ARREADY), 64'd0);
        rb("incr0", 32'd1, 1'b0, RESP_OKAY, 1'b0);
        rb("incr1", 32'd2, 1'b0, RESP_OKAY, 1'b0);
        rb("incr2", 32'd3, 1'b0, RESP_OKAY, 1'b0);
        rb("incr3", 32'd4, 1'b1, RESP_OKAY, 1'b0);
        chk("incr_rvalid_done", 64'(bus.S_AXI_RVALID), 64'd0);

        // WRAP read from 0x18: 0x18, 0x1C, 0x10, 0x14
        ar(6'h18, 8'd3, 3'd2, BURST_WRAP, 1'b1);
        rb("wrap0", 32'd3, 1'b0, RESP_OKAY, 1'b1);
        rb("wrap1", 32'd4, 1'b0, RESP_OKAY, 1'b1);
        rb("wrap2", 32'd1, 1'b0, RESP_OKAY, 1'b1);
        rb("wrap3", 32'd2, 1'b1, RESP_OKAY, 1'b1);

        // Byte strobes
        aw(6'h20, 8'd0, 3'd2, BURST_INCR, 1'b0);
        wb(32'h0, 4'hF, 1'b1);
        bchk("strb_clr", RESP_OKAY, 1'b0);
        aw(6'h20, 8'd0, 3'd2, BURST_INCR, 1'b0);
        wb(32'hAABBCCDD, 4'h5, 1'b1);
        bchk("strb", RESP_OKAY, 1'b0);
        ar(6'h20, 8'd0, 3'd2, BURST_INCR, 1'b0);
        rb("strb", 32'h00BB00DD, 1'b1, RESP_OKAY, 1'b0);

        // RREADY 1,0,0,1 across a 4-beat read
        ar(6'h10, 8'd3, 3'd2, BURST_INCR, 1'b0);
        rb("stall0", 32'd1, 1'b0, RESP_OKAY, 1'b0);
        bus.S_AXI_RREADY = 1'b0;
        chk("stall_hold1", 64'(bus.S_AXI_RDATA), 64'd2);
        tick();
        chk("stall_hold2", 64'(bus.S_AXI_RDATA), 64'd2);
        chk("stall_rvalid", 64'(bus.S_AXI_RVALID), 64'd1);
        tick();
        bus.S_AXI_RREADY = 1'b1;
        rb("stall1", 32'd2, 1'b0, RESP_OKAY, 1'b0);
        rb("stall2", 32'd3, 1'b0, RESP_OKAY, 1'b0);
        rb("stall3", 32'd4, 1'b1, RESP_OKAY, 1'b0);

        // FIXED write with a WVALID gap: both beats land on 0x28
        aw(6'h28, 8'd1, 3'd2, BURST_FIXED, 1'b1);
        wb(32'h0000000A, 4'hF, 1'b0);
        tick(); tick();
        chk("gap_wready", 64'(bus.S_AXI_WREADY), 64'd1);
        chk("gap_bvalid", 64'(bus.S_AXI_BVALID), 64'd0);
        wb(32'h0000000B, 4'hF, 1'b1);
        bchk("fixed", RESP_OKAY, 1'b1);
        ar(6'h28, 8'd1, 3'd2, BURST_FIXED, 1'b1);
        rb("fixed0", 32'h0000000B, 1'b0, RESP_OKAY, 1'b1);
        rb("fixed1", 32'h0000000B, 1'b1, RESP_OKAY, 1'b1);

        // INCR crossing the top of the address space wraps to 0x00
        aw(6'h3C, 8'd1, 3'd2, BURST_INCR, 1'b0);
        wb(32'h11111111, 4'hF, 1'b0);
        wb(32'h22222222, 4'hF, 1'b1);
        bchk("modwrap", RESP_OKAY, 1'b0);
        ar(6'h3C, 8'd1, 3'd2, BURST_INCR, 1'b0);
        rb("modwrap0", 32'h11111111, 1'b0, RESP_OKAY, 1'b0);
        rb("modwrap1", 32'h22222222, 1'b1, RESP_OKAY, 1'b0);

        // Reset in the middle of a write burst
        aw(6'h30, 8'd3, 3'd2, BURST_INCR, 1'b1);
        wb(32'h55, 4'hF, 1'b0);
        ARESETn = 1'b0;
        #1;
        chk("mid_wready", 64'(bus.S_AXI_WREADY), 64'd0);
        chk("mid_awready", 64'(bus.S_AXI_AWREADY), 64'd0);
        chk("mid_bid", 64'(bus.S_AXI_BID), 64'd0);
        chk("mid_rvalid", 64'(bus.S_AXI_RVALID), 64'd0);
        tick();
        ARESETn = 1'b1;
        tick();
        chk("mid_rel_awready", 64'(bus.S_AXI_AWREADY), 64'd1);
        chk("mid_rel_wready", 64'(bus.S_AXI_WREADY), 64'd0);
        aw(6'h2C, 8'd0, 3'd2, BURST_INCR, 1'b0);
        wb(32'h66, 4'hF, 1'b1);
        bchk("post_rst", RESP_OKAY, 1'b0);
        ar(6'h2C, 8'd0, 3'd2, BURST_INCR, 1'b0);
        rb("post_rst", 32'h66, 1'b1, RESP_OKAY, 1'b0);

        // WRAP with LEN=2: illegal length
        aw(6'h30, 8'd3, 3'd2, BURST_INCR, 1'b0);
        wb(32'hA0, 4'hF, 1'b0); wb(32'hA1, 4'hF, 1'b0);
        wb(32'hA2, 4'hF, 1'b0); wb(32'hA3, 4'hF, 1'b1);
        bchk("pre_bad", RESP_OKAY, 1'b0);
        aw(6'h34, 8'd2, 3'd2, BURST_WRAP, 1'b1);
        wb(32'hC1, 4'hF, 1'b0); wb(32'hC2, 4'hF, 1'b0); wb(32'hC3, 4'hF, 1'b1);
`ifdef AXI_MEM_ERR_CHECK_EN
        bchk("bad_wrap", RESP_SLVERR, 1'b1);
        ar(6'h30, 8'd3, 3'd2, BURST_INCR, 1'b0);
        rb("bad_keep0", 32'hA0, 1'b0, RESP_OKAY, 1'b0);
        rb("bad_keep1", 32'hA1, 1'b0, RESP_OKAY, 1'b0);
        rb("bad_keep2", 32'hA2, 1'b0, RESP_OKAY, 1'b0);
        rb("bad_keep3", 32'hA3, 1'b1, RESP_OKAY, 1'b0);
        ar(6'h30, 8'd2, 3'd2, BURST_WRAP, 1'b1);
        rb("bad_rd0", 32'h0, 1'b0, RESP_SLVERR, 1'b1);
        rb("bad_rd1", 32'h0, 1'b0, RESP_SLVERR, 1'b1);
        rb("bad_rd2", 32'h0, 1'b1, RESP_SLVERR, 1'b1);
`else
        bchk("bad_wrap", RESP_OKAY, 1'b1);
        ar(6'h30, 8'd3, 3'd2, BURST_INCR, 1'b0);
        rb("bad_incr0", 32'hA0, 1'b0, RESP_OKAY, 1'b0);
        rb("bad_incr1", 32'hC1, 1'b0, RESP_OKAY, 1'b0);
        rb("bad_incr2", 32'hC2, 1'b0, RESP_OKAY, 1'b0);
        rb("bad_incr3", 32'hC3, 1'b1, RESP_OKAY, 1'b0);
        ar(6'h30, 8'd2, 3'd2, BURST_WRAP, 1'b1);
        rb("bad_rd0", 32'hA0, 1'b0, RESP_OKAY, 1'b1);
        rb("bad_rd1", 32'hC1, 1'b0, RESP_OKAY, 1'b1);
        rb("bad_rd2", 32'hC2, 1'b1, RESP_OKAY, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
